// File: rtl/pmem_responder.sv
// pmem_responder: behavioural line memory standing in for main memory behind a cache.
// Each accepted request completes with a one-cycle pmem_resp LATENCY cycles later.
// Optional feature macro: PMEM_RESPONDER_STATS_EN adds saturating read/write completion
// counters; when it is undefined, rd_count and wr_count are tied to 0.
//
// state | meaning
// IDLE  | waiting for pmem_read/pmem_write; a request here is accepted at the edge
// BUSY  | latency down-counter running; the request line must stay high
// RESP  | pmem_resp high for one cycle; write commit / count update at the edge ending it
module pmem_responder #(
  parameter int LATENCY   = 4,
  parameter int LINE_BITS = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         pmem_read,
  input  logic         pmem_write,
  input  logic [15:0]  pmem_address,
  input  logic [127:0] pmem_wdata,
  output logic [127:0] pmem_rdata,
  output logic         pmem_resp,
  output logic         protocol_err,
  output logic [15:0]  rd_count,
  output logic [15:0]  wr_count
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam int         LINES    = 1 << LINE_BITS;
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

  state_t                 state, state_nxt;
  logic [3:0]             cnt, cnt_nxt;
  logic                   accept, abort;
  logic                   op_wr_q;
  logic [LINE_BITS-1:0]   line_q;
  logic [127:0]           wdata_q;
  logic [127:0]           mem [LINES];
  logic [LINE_BITS-1:0]   addr_line;
  logic                   resp_is_rd;
  logic [LINE_BITS-1:0]   resp_line;
  logic                   unused_addr;

  assign addr_line   = pmem_address[LINE_BITS+3:4];
  // Offset bits and upper alias bits are intentionally dropped.
  assign unused_addr = ^{pmem_address[15:LINE_BITS+4], pmem_address[3:0]};
  assign pmem_resp   = (state == RESP);

  // Next-state, latency down-counter and accept/abort decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (pmem_read || pmem_write) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_nxt = RESP;
          end else begin
            state_nxt = BUSY;
            cnt_nxt   = LAT_LOAD;
          end
        end
      end
      BUSY: begin
        // Dropping the accepted op's request line cancels the transaction.
        if (op_wr_q ? !pmem_write : !pmem_read) begin
          abort     = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = 4'd0;
        end else if (cnt == 4'd1) begin
          state_nxt = RESP;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Op and line of the transaction entering RESP; the LATENCY=1 path has not latched them yet.
  always_comb begin
    resp_is_rd = accept ? !pmem_write : !op_wr_q;
    resp_line  = accept ? addr_line : line_q;
  end

  // State register and latency counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request capture at acceptance; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_wr_q <= 1'b0;
      line_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      op_wr_q <= pmem_write;
      line_q  <= addr_line;
      wdata_q <= pmem_wdata;
    end
  end

  // Sticky protocol error: simultaneous read+write, or a request dropped mid-flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      protocol_err <= 1'b0;
    end else if ((accept && pmem_read && pmem_write) || abort) begin
      protocol_err <= 1'b1;
    end
  end

  // Read data loads on entry to RESP and holds until the next read completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pmem_rdata <= '0;
    end else if (state_nxt == RESP && resp_is_rd) begin
      pmem_rdata <= mem[resp_line];
    end
  end

  // Line storage; a write commits at the edge ending its RESP cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LINES; i++) mem[i] <= '0;
    end else if (state == RESP && op_wr_q) begin
      mem[line_q] <= wdata_q;
    end
  end

`ifdef PMEM_RESPONDER_STATS_EN
  // Saturating completion counters, updated at the edge ending RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else if (state == RESP) begin
      if (op_wr_q) begin
        if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
      end else begin
        if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
    end
  end
`else
  assign rd_count = 16'd0;
  assign wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder (LATENCY=4, LINE_BITS=6).
module tb_pmem_responder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         pmem_read = 1'b0;
  logic         pmem_write = 1'b0;
  logic [15:0]  pmem_address = '0;
  logic [127:0] pmem_wdata = '0;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic         protocol_err;
  logic [15:0]  rd_count;
  logic [15:0]  wr_count;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] D_A5 = {16{8'hA5}};
  localparam logic [127:0] D1   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] D2   = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] D3   = 128'h5A5A_5A5A_C3C3_C3C3_0F0F_0F0F_F0F0_F0F0;
  localparam logic [127:0] DX   = 128'h1111_2222_3333_4444_5555_6666_7777_8888;

`ifdef PMEM_RESPONDER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  pmem_responder #(.LATENCY(4), .LINE_BITS(6)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .protocol_err (protocol_err),
    .rd_count     (rd_count),
    .wr_count     (wr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request, hold it until pmem_resp is seen, then drop it in the RESP cycle.
  // lat = sample index of the resp (first sample after the acceptance edge is 1); 0 on timeout.
  task automatic do_txn(input logic rd, input logic wr, input logic [15:0] addr,
                        input logic [127:0] wd, output int lat, output logic [127:0] rdat);
    lat  = 0;
    rdat = '0;
    @(negedge clk);
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = addr;
    pmem_wdata   = wd;
    @(posedge clk); #1;
    for (int c = 1; c <= 20; c++) begin
      if (pmem_resp) begin
        lat  = c;
        rdat = pmem_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = 16'hFFFF;
    pmem_wdata   = '1;
    @(posedge clk); #1;
  endtask

  int           lat;
  logic [127:0] rd;
  int           hits [3];
  int           nhit;
  logic         seen;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_resp",  128'(pmem_resp), 128'd0);
    chk("rst_rdata", pmem_rdata, 128'd0);
    chk("rst_err",   128'(protocol_err), 128'd0);
    chk("rst_rdcnt", 128'(rd_count), 128'd0);
    chk("rst_wrcnt", 128'(wr_count), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Write then read the same line via a different offset
    do_txn(1'b0, 1'b1, 16'h0123, D_A5, lat, rd);
    chk("wr_lat", 128'(lat), 128'd4);
    do_txn(1'b1, 1'b0, 16'h0120, '0, lat, rd);
    chk("rd_lat",  128'(lat), 128'd4);
    chk("rd_data", rd, D_A5);

    // Aliasing: 0x0400 and 0x0000 hit line 0
    do_txn(1'b0, 1'b1, 16'h0400, D1, lat, rd);
    do_txn(1'b1, 1'b0, 16'h0000, '0, lat, rd);
    chk("alias_data", rd, D1);

    // A write leaves pmem_rdata unchanged
    do_txn(1'b0, 1'b1, 16'h0010, D2, lat, rd);
    chk("wr_keeps_rdata", pmem_rdata, D1);

    // Continuous read: pulses at samples 4, 9, 14, each one cycle wide
    nhit = 0;
    @(negedge clk);
    pmem_read    = 1'b1;
    pmem_address = 16'h0120;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (pmem_resp) begin
        if (nhit < 3) hits[nhit] = c;
        nhit++;
      end
    end
    @(negedge clk);
    pmem_read = 1'b0;
    chk("stream_npulse", 128'(nhit), 128'd3);
    chk("stream_first",  128'(hits[0]), 128'd4);
    chk("stream_gap1",   128'(hits[1] - hits[0]), 128'd5);
    chk("stream_gap2",   128'(hits[2] - hits[1]), 128'd5);
    chk("stream_data",   pmem_rdata, D_A5);
    chk("stream_err",    128'(protocol_err), 128'd0);
    @(posedge clk); #1;
    chk("cnt_rd_a", 128'(rd_count), STATS ? 128'd5 : 128'd0);
    chk("cnt_wr_a", 128'(wr_count), STATS ? 128'd3 : 128'd0);

    // Abort: write to line 5 dropped two cycles after acceptance
    @(negedge clk);
    pmem_write   = 1'b1;
    pmem_address = 16'h0050;
    pmem_wdata   = DX;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    pmem_write = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (pmem_resp) seen = 1'b1;
    end
    chk("abort_noresp", 128'(seen), 128'd0);
    chk("abort_err",    128'(protocol_err), 128'd1);
    chk("abort_wrcnt",  128'(wr_count), STATS ? 128'd3 : 128'd0);
    do_txn(1'b1, 1'b0, 16'h0050, '0, lat, rd);
    chk("abort_nowrite", rd, 128'd0);

    // Read and write together: performed as a write
    do_txn(1'b1, 1'b1, 16'h0060, D3, lat, rd);
    chk("both_lat", 128'(lat), 128'd4);
    chk("both_err", 128'(protocol_err), 128'd1);
    do_txn(1'b1, 1'b0, 16'h0060, '0, lat, rd);
    chk("both_data", rd, D3);
    chk("err_sticky", 128'(protocol_err), 128'd1);
    chk("cnt_rd_b", 128'(rd_count), STATS ? 128'd7 : 128'd0);
    chk("cnt_wr_b", 128'(wr_count), STATS ? 128'd4 : 128'd0);

    // Reset in the middle of a write's BUSY phase
    @(negedge clk);
    pmem_write   = 1'b1;
    pmem_address = 16'h0070;
    pmem_wdata   = D2;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_resp",  128'(pmem_resp), 128'd0);
    chk("mid_rst_rdata", pmem_rdata, 128'd0);
    chk("mid_rst_err",   128'(protocol_err), 128'd0);
    chk("mid_rst_rdcnt", 128'(rd_count), 128'd0);
    chk("mid_rst_wrcnt", 128'(wr_count), 128'd0);
    pmem_write = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do_txn(1'b1, 1'b0, 16'h0060, '0, lat, rd);
    chk("post_rst_lat",   128'(lat), 128'd4);
    chk("post_rst_clear", rd, 128'd0);
    do_txn(1'b1, 1'b0, 16'h0070, '0, lat, rd);
    chk("post_rst_nowr",  rd, 128'd0);
    chk("post_rst_rdcnt", 128'(rd_count), STATS ? 128'd2 : 128'd0);
    chk("post_rst_wrcnt", 128'(wr_count), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
